// File: rtl/clk_div_switch.sv
// Glitch-free programmable clock divider. Ratio changes land only at a period
// boundary, after a forced-low gap, and are acknowledged with a one-cycle pulse.
module clk_div_switch #(
   parameter int unsigned DIV_W     = 4,
   parameter int unsigned RST_RATIO = 4,
   parameter int unsigned GAP       = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             div_req,
   input  logic [DIV_W-1:0] div_ratio,
   output logic             div_ack,
   output logic             busy,
   output logic             req_err,
   output logic [DIV_W-1:0] cur_ratio,
   output logic             clk_out
);

   localparam int unsigned GCNT_W   = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_GAPW   = 2'd1,
      S_SWITCH = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DIV_W-1:0]    cnt_q, cnt_d;
   logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
   logic [DIV_W-1:0]    pend_q, pend_d;
   logic [DIV_W-1:0]    cur_q, cur_d;
   logic                busy_q, busy_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic                clk_q, clk_d;

   logic [DIV_W-1:0]    half_c;
   logic [DIV_W-1:0]    last_c;
   logic                gated_c;
   logic                boundary_c;

   // Period geometry of the ratio in force; a gated output is always at a boundary.
   assign half_c     = cur_q >> 1;
   assign last_c     = cur_q - DIV_W'(1);
   assign gated_c    = (cur_q == '0);
   assign boundary_c = gated_c || (cnt_q == last_c);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gcnt_d  = gcnt_q;
      pend_d  = pend_q;
      cur_d   = cur_q;
      busy_d  = busy_q;
      ack_d   = 1'b0;
      err_d   = div_req & busy_q;
      clk_d   = 1'b0;

      // Capture a new ratio; ratio 1 cannot be made glitch-free, so it runs as 2.
      if (div_req && !busy_q) begin
         pend_d = (div_ratio == DIV_W'(1)) ? DIV_W'(2) : div_ratio;
         busy_d = 1'b1;
      end

      case (state_q)
         S_RUN: begin
            if (gated_c) begin
               cnt_d = '0;
            end else begin
               clk_d = (cnt_q < half_c);
               cnt_d = (cnt_q == last_c) ? '0 : cnt_q + DIV_W'(1);
            end
            if (boundary_c && busy_q) begin
               gcnt_d  = '0;
               state_d = (GAP > 0) ? S_GAPW : S_SWITCH;
            end
         end
         S_GAPW: begin
            if (gcnt_q == GCNT_W'(GAP_LAST)) begin
               state_d = S_SWITCH;
            end else begin
               gcnt_d = gcnt_q + GCNT_W'(1);
            end
         end
         S_SWITCH: begin
            cur_d   = pend_q;
            cnt_d   = '0;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_RUN;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
         gcnt_q  <= '0;
         pend_q  <= '0;
         cur_q   <= DIV_W'(RST_RATIO);
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         clk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gcnt_q  <= gcnt_d;
         pend_q  <= pend_d;
         cur_q   <= cur_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         clk_q   <= clk_d;
      end
   end

   assign div_ack   = ack_q;
   assign busy      = busy_q;
   assign req_err   = err_q;
   assign cur_ratio = cur_q;
   assign clk_out   = clk_q;

endmodule
